stream_sort8: RTL and testbench
===============================

Name: stream_sort8

Overview:
- Serial-stream sorter, the stream-facing counterpart of the team's parallel 8-input sorting network.
- Accepts a block of N unsigned words one per handshake and sorts it in place using iterative odd-even transposition, one compare stage per cycle.
- Emits the sorted block one word per handshake, with a last-word flag.
- Connects byte-serial sources/sinks to the sorting datapath without an 8-wide bus.

Parameters:
- W, 8, data word width in bits.
- N, 8, words per block; even, at least 2.
- DESC, 0, 0 = ascending output order, 1 = descending.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- in_data  input  W  unsigned input word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  W  sorted output word.
- out_last  output  1  marks the final word of the block.
- busy  output  1  high in SORT or DRAIN.

Behaviour:
- Storage: register array r[0..N-1], W bits each. Counters: load index li, pass counter pc, drain index di, each clog2(N)+1 bits.
- Reset (rst=1 at an edge, from any state, mid-operation included):
  - state=LOAD; li, pc, di = 0; all r = 0.
  - in_ready=0 while rst is high; out_valid=0, out_last=0, out_data=0, busy=0.
  - Any partial block is discarded.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: r[li] <= in_data, li <= li+1.
  - When the N-th word is accepted: li <= 0, state <= SORT on the same edge.
  - in_valid gaps are allowed; li holds during gaps.
- SORT:
  - in_ready=0, out_valid=0. Exactly N cycles, pc = 0..N-1.
  - Even pc: compare-exchange pairs (0,1),(2,3),…,(N-2,N-1).
  - Odd pc: compare-exchange pairs (1,2),(3,4),…,(N-3,N-2); r[0] and r[N-1] hold.
  - Compare is unsigned.
    - DESC=0: swap iff r[i] > r[i+1].
    - DESC=1: swap iff r[i] < r[i+1].
    - Equal values are never swapped.
  - After pass N-1: pc <= 0, state <= DRAIN.
- DRAIN:
  - out_valid=1, out_data=r[di], out_last=(di==N-1).
  - On out_valid&&out_ready: di <= di+1.
  - On the handshake with out_last=1: di <= 0, state <= LOAD.
  - out_data and out_last hold stable while out_valid&&!out_ready.
  - in_ready=0 throughout DRAIN; no overlap of load and drain.
- Latency:
  - Last input accepted at edge t; out_valid rises after edge t+N, i.e. first visible in cycle t+N+1.
  - Minimum block period with always-ready endpoints is 3N cycles.
- out_data, out_valid, out_last and in_ready are decoded from registered state only; no combinational path from in_* to out_* or from out_ready to in_ready.
- Outside DRAIN: out_data=0, out_last=0.

Test Plan:
- Reverse load: load 8,7,6,5,4,3,2,1 with DESC=0 and out_ready=1.
  - Output is 1,2,…,8.
  - out_last is high only with 8.
  - out_valid first asserts exactly 9 cycles after the final input acceptance.
- Extremes and duplicates: load 255,0,255,0,128,128,1,254.
  - Output is 0,0,1,128,128,254,255,255.
  - With DESC=1 the output is the exact reverse.
- Backpressure and load gaps:
  - Drive out_ready with pattern 1,0,0,1,0,1… and insert random in_valid gaps during LOAD.
  - Exactly 8 words emerge, correctly sorted, with no duplicates or drops.
  - out_data is stable during every stall.
  - in_ready stays 0 from SORT entry until the last output handshake.
- Reset mid-SORT:
  - Assert rst for 1 cycle at pass 3.
  - out_valid=0 and busy=0 after the reset edge; in_ready=1 the following cycle.
  - Next block 9,3,7,1,8,2,6,4 sorts to 1,2,3,4,6,7,8,9.
- Reset mid-DRAIN and mid-LOAD:
  - Assert rst after 3 outputs, and separately after 5 loaded words.
  - No further output from the aborted block.
  - A fresh 8-word block sorts correctly.
- Back-to-back blocks: stream 4 random blocks with in_valid and out_ready held high.
  - Every block matches a reference sort.
  - Block period is exactly 24 cycles.

Source files
------------

// File: rtl/stream_sort8.sv
// stream_sort8: loads an N-word block serially, sorts it in place by odd-even transposition, drains it serially
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data load side;
//        out_valid/out_ready/out_data/out_last drain side; busy high while sorting or draining
module stream_sort8 #(
  parameter int W    = 8,
  parameter int N    = 8,
  parameter int DESC = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  r_q [N];
  logic [W-1:0]  r_d [N];
  logic [CW-1:0] li_q, li_d, pc_q, pc_d, di_q, di_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      li_q    <= '0;
      pc_q    <= '0;
      di_q    <= '0;
      for (int i = 0; i < N; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      li_q    <= li_d;
      pc_q    <= pc_d;
      di_q    <= di_d;
      r_q     <= r_d;
    end
  end
  always_comb begin
    state_d = state_q;
    li_d    = li_q;
    pc_d    = pc_q;
    di_d    = di_q;
    r_d     = r_q;
    if (state_q == LOAD && in_valid) begin
      r_d[li_q[CW-2:0]] = in_data;
      li_d    = li_q == LAST ? '0 : li_q + CW'(1);
      state_d = li_q == LAST ? SORT : LOAD;
    end
    if (state_q == SORT) begin
      // even passes pair (0,1),(2,3)...; odd passes pair (1,2),(3,4)... leaving the ends alone
      for (int i = 0; i < N - 1; i++)
        if (i[0] == pc_q[0] && (DESC != 0 ? r_q[i] < r_q[i+1] : r_q[i] > r_q[i+1])) begin
          r_d[i]   = r_q[i+1];
          r_d[i+1] = r_q[i];
        end
      pc_d    = pc_q == LAST ? '0 : pc_q + CW'(1);
      state_d = pc_q == LAST ? DRAIN : SORT;
    end
    if (state_q == DRAIN && out_ready) begin
      di_d    = di_q == LAST ? '0 : di_q + CW'(1);
      state_d = di_q == LAST ? LOAD : DRAIN;
    end
  end
  assign in_ready  = !rst && state_q == LOAD;
  assign out_valid = !rst && state_q == DRAIN;
  assign out_data  = out_valid ? r_q[di_q[CW-2:0]] : '0;
  assign out_last  = out_valid && di_q == LAST;
  assign busy      = !rst && state_q != LOAD;
endmodule

// File: tb/tb_stream_sort8.sv
// tb_stream_sort8: randomized self-checking bench for stream_sort8, ascending and descending instances side by side
module tb_stream_sort8;
  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0;
  logic [7:0] in_data = 0;
  logic       out_ready = 0;
  logic       a_in_ready, a_out_valid, a_out_last, a_busy;
  logic       d_in_ready, d_out_valid, d_out_last, d_busy;
  logic [7:0] a_out_data, d_out_data;
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         first_cyc = 0;
  bit         pat [6] = '{1, 0, 0, 1, 0, 1};
  logic [7:0] blk [8];
  stream_sort8 #(.W(8), .N(8), .DESC(0)) u_asc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy)
  );
  stream_sort8 #(.W(8), .N(8), .DESC(1)) u_desc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data), .out_last(d_out_last), .busy(d_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic load_block(input logic [7:0] b [8], input int n, input bit gaps);
    int  i = 0;
    int  g = 0;
    bit  fire;
    while (i < n && g < 200) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = b[i];
      #1;
      fire = in_valid && a_in_ready;
      if (fire && i == 0) first_cyc = cyc;
      if (fire) acc_cyc = cyc;
      @(negedge clk);
      if (fire) i++;
      g++;
    end
    in_valid = 0;
    if (g >= 200) check("load_timeout", i, n);
  endtask
  task automatic drain_block(input logic [7:0] b [8], input bit bp, input int stop_after, input bit lat);
    logic [7:0] asc [$];
    logic [7:0] dsc [$];
    logic [7:0] held = 0;
    bit         stalled = 0;
    bit         seen = 0;
    int         k = 0;
    int         g = 0;
    int         p = 0;
    for (int j = 0; j < 8; j++) asc.push_back(b[j]);
    asc.sort();
    dsc = asc;
    dsc.reverse();
    while (k < stop_after && g < 300) begin
      out_ready = bp ? pat[p % 6] : 1'b1;
      p++;
      #1;
      check("in_ready_busy", {31'b0, a_in_ready}, 0);
      if (a_out_valid) begin
        if (lat && !seen) check("latency", cyc - acc_cyc, 9);
        seen = 1;
        if (stalled) check("stall_data", a_out_data, held);
        if (out_ready) begin
          check("asc_data", a_out_data, asc[k]);
          check("desc_data", d_out_data, dsc[k]);
          check("last", {31'b0, a_out_last}, k == 7);
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = a_out_data;
        end
      end
      @(negedge clk);
      g++;
    end
    out_ready = 0;
    if (g >= 300) check("drain_timeout", k, stop_after);
  endtask
  task automatic full_block(input bit gaps, input bit bp);
    load_block(blk, 8, gaps);
    drain_block(blk, bp, 8, 1);
    #1;
    check("post_valid", {31'b0, a_out_valid}, 0);
    @(negedge clk);
  endtask
  task automatic pulse_rst();
    rst = 1;
    #1;
    check("rst_in_ready", {31'b0, a_in_ready}, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_out_valid", {31'b0, a_out_valid}, 0);
    check("rst_busy", {31'b0, a_busy}, 0);
    check("rst_then_ready", {31'b0, a_in_ready}, 1);
    @(negedge clk);
  endtask
  initial begin
    int prev;
    int nv;
    @(negedge clk);
    #1;
    check("reset_in_ready", {31'b0, a_in_ready}, 0);
    check("reset_out_valid", {31'b0, a_out_valid}, 0);
    check("reset_busy", {31'b0, a_busy}, 0);
    check("reset_data", a_out_data, 0);
    check("reset_last", {31'b0, a_out_last}, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("idle_in_ready", {31'b0, a_in_ready}, 1);
    @(negedge clk);
    blk = '{8, 7, 6, 5, 4, 3, 2, 1};
    full_block(0, 0);
    blk = '{255, 0, 255, 0, 128, 128, 1, 254};
    full_block(0, 0);
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < 8; j++) blk[j] = 8'($urandom_range(0, t == 0 ? 3 : 255));
      full_block(1, 1);
    end
    blk = '{200, 100, 50, 25, 12, 6, 3, 1};
    load_block(blk, 8, 0);
    repeat (3) @(negedge clk);
    pulse_rst();
    blk = '{9, 3, 7, 1, 8, 2, 6, 4};
    full_block(0, 0);
    for (int j = 0; j < 8; j++) blk[j] = 8'($urandom);
    load_block(blk, 8, 0);
    drain_block(blk, 0, 3, 1);
    pulse_rst();
    nv = 0;
    repeat (12) begin
      #1;
      nv += int'(a_out_valid);
      @(negedge clk);
    end
    check("aborted_drain_quiet", nv, 0);
    blk = '{11, 99, 42, 42, 0, 7, 250, 13};
    full_block(1, 0);
    blk = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_block(blk, 5, 0);
    pulse_rst();
    blk = '{60, 50, 40, 30, 20, 10, 5, 70};
    full_block(0, 1);
    prev = -1;
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < 8; j++) blk[j] = 8'($urandom);
      load_block(blk, 8, 0);
      if (prev >= 0) check("block_period", first_cyc - prev, 24);
      prev = first_cyc;
      drain_block(blk, 0, 8, 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
